// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart_m transmitter
// among NREQ byte producers, one load pulse per byte.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   req[NREQ]       byte pending per requester (held until ack)
//   reqdata[8*NREQ] packed bytes, requester i at [8i+7:8i]
//   ack[NREQ]       one-cycle pulse: byte of requester i taken by uart_m
//   load, d[8]      load strobe and byte to uart_m
//   txbusy          uart_m busy
//   gnt[IDW]        index currently or last served
//   active          high outside IDLE
//   err             sticky txbusy-never-rose flag
//
// Optional: define UART_TX_ARBITER_LOCK_EN to add reqlast[NREQ]; the
// winner keeps the grant until a byte flagged last completes or times out.
module uart_tx_arbiter #(
  parameter int NREQ        = 3,
  parameter int IDW         = 2,
  parameter int BUSYTIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] reqdata,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]   reqlast,
`endif
  output logic [NREQ-1:0]   ack,
  output logic              load,
  output logic [7:0]        d,
  input  logic              txbusy,
  output logic [IDW-1:0]    gnt,
  output logic              active,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAITHI,
    WAITLO
  } state_t;

  state_t          state, state_n;
  logic            load_n;
  logic [7:0]      d_n;
  logic [NREQ-1:0] ack_n;
  logic [IDW-1:0]  gnt_n;
  logic            err_n;
  logic            active_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [7:0]      cnt, cnt_n;

  logic            go;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  nxt;
  logic [7:0]      bytes [NREQ];

`ifdef UART_TX_ARBITER_LOCK_EN
  logic            lock, lock_n;
  logic            last, last_n;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign bytes[i] = reqdata[8*i +: 8];
  end

  // Successor of the served index; the served requester
  // drops to lowest priority.
  assign nxt = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  // First requester at or above ptr, wrapping at NREQ.
  always_comb begin
    int j;
    j    = 0;
    go   = 1'b0;
    pick = ptr;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!go && req[IDW'(j)]) begin
        go   = 1'b1;
        pick = IDW'(j);
      end
    end
`ifdef UART_TX_ARBITER_LOCK_EN
    if (lock) begin
      go   = req[gnt];
      pick = gnt;
    end
`endif
  end

  always_comb begin
    state_n = state;
    load_n  = 1'b0;
    d_n     = d;
    ack_n   = '0;
    gnt_n   = gnt;
    err_n   = err;
    ptr_n   = ptr;
    cnt_n   = cnt;
`ifdef UART_TX_ARBITER_LOCK_EN
    lock_n  = lock;
    last_n  = last;
`endif
    unique case (state)
      IDLE: begin
        // txbusy high here is a foreign or leftover
        // transfer; never load on top of it.
        if (!txbusy && go) begin
          gnt_n   = pick;
          d_n     = bytes[pick];
          load_n  = 1'b1;
          state_n = LOAD;
`ifdef UART_TX_ARBITER_LOCK_EN
          last_n  = reqlast[pick];
`endif
        end
      end
      LOAD: begin
        cnt_n   = '0;
        state_n = WAITHI;
      end
      WAITHI: begin
        // txbusy is tested first so a late rise on the
        // timeout cycle still counts as success.
        if (txbusy) begin
          ack_n   = NREQ'(1) << gnt;
          state_n = WAITLO;
`ifdef UART_TX_ARBITER_LOCK_EN
          lock_n  = !last;
          if (last) ptr_n = nxt;
`else
          ptr_n   = nxt;
`endif
        end else if (cnt >= 8'(BUSYTIMEOUT)) begin
          err_n   = 1'b1;
          ptr_n   = nxt;
          state_n = IDLE;
`ifdef UART_TX_ARBITER_LOCK_EN
          lock_n  = 1'b0;
`endif
        end else if (cnt != 8'hff) begin
          cnt_n = cnt + 8'd1;
        end
      end
      WAITLO: begin
        if (!txbusy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    active_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      load   <= 1'b0;
      d      <= '0;
      ack    <= '0;
      gnt    <= '0;
      err    <= 1'b0;
      active <= 1'b0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      load   <= load_n;
      d      <= d_n;
      ack    <= ack_n;
      gnt    <= gnt_n;
      err    <= err_n;
      active <= active_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
    end
  end

`ifdef UART_TX_ARBITER_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock <= 1'b0;
      last <= 1'b0;
    end else begin
      lock <= lock_n;
      last <= last_n;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter
// with a queue-based round-robin reference and a uart_m busy model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;
  localparam int TO   = 15;

  typedef struct packed {
    logic [IDW-1:0] idx;
    logic [7:0]     dat;
  } ld_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] reqdata = '0;
  logic [NREQ-1:0]   ack;
  logic              load;
  logic [7:0]        d;
  logic              txbusy;
  logic [IDW-1:0]    gnt;
  logic              active;
  logic              err;

  logic mbusy = 1'b0;
  logic fbusy = 1'b0;
  logic dead  = 1'b0;
  int   lo    = 2;

  assign txbusy = mbusy | fbusy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .BUSYTIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .reqdata(reqdata),
`ifdef UART_TX_ARBITER_LOCK_EN
    .reqlast({NREQ{1'b1}}),
`endif
    .ack(ack),
    .load(load),
    .d(d),
    .txbusy(txbusy),
    .gnt(gnt),
    .active(active),
    .err(err)
  );

  logic [7:0] pend [NREQ][$];
  ld_t        lq[$];
  int         aq[$];
  int         mptr = 0;
  int         nvec = 0;
  int         nbad = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: round-robin over the pending queues as
  // they stand now; served index gets lowest priority.
  task automatic schedule();
    int  cnt [NREQ];
    int  pos [NREQ];
    int  rem;
    ld_t e;
    rem = 0;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = pend[i].size();
      pos[i] = 0;
      rem += cnt[i];
    end
    while (rem > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mptr + k) % NREQ;
        if (cnt[j] > 0) begin
          e.idx = IDW'(j);
          e.dat = pend[j][pos[j]];
          lq.push_back(e);
          aq.push_back(j);
          pos[j]++;
          cnt[j]--;
          rem--;
          mptr = (j + 1) % NREQ;
          break;
        end
      end
    end
  endtask

  task automatic drain(string nm);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      done = (lq.size() == 0) && (aq.size() == 0) &&
             !active && !txbusy;
      for (int i = 0; i < NREQ; i++)
        if (pend[i].size() != 0) done = 1'b0;
    end
    check({"drain_", nm}, 32'(done), 32'd1);
  endtask

  // Requesters: hold byte at queue head until acked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && pend[i].size() != 0)
          void'(pend[i].pop_front());
        req[i] = (pend[i].size() != 0);
        reqdata[8*i +: 8] = 8'h00;
        if (req[i]) reqdata[8*i +: 8] = pend[i][0];
      end
    end
  end

  // uart_m model: busy from the cycle after load.
  initial begin
    int left;
    bit arm;
    left = 0;
    arm  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (arm) begin
        mbusy = 1'b1;
        left  = $urandom_range(12, lo);
        arm   = 1'b0;
      end else if (left > 0) begin
        left--;
        if (left == 0) mbusy = 1'b0;
      end
      if (load && !dead) arm = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on load and ack.
  int   cyc = 0;
  int   last_ld = -100;
  logic busy_edge = 1'b0;
  ld_t  got;
  int   ai;

  always @(posedge clk) busy_edge = txbusy;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (load) begin
        check("load_while_busy", 32'(busy_edge), 32'd0);
        if (lq.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL spurious_load: got gnt %0d d %0h expected none",
                   gnt, d);
        end else begin
          got = lq.pop_front();
          check("gnt", 32'(gnt), 32'(got.idx));
          check("d", 32'(d), 32'(got.dat));
        end
        last_ld = cyc;
      end
      if (ack != '0) begin
        if (aq.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL spurious_ack: got %0b expected none", ack);
        end else begin
          ai = aq.pop_front();
          check("ack_vec", 32'(ack), 32'(1) << ai);
          check("ack_latency", 32'(cyc - last_ld), 32'd2);
        end
      end
    end
  end

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    check("rst_load", 32'(load), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    rst = 1'b0;

    @(negedge clk);
    pend[2].push_back(8'h5a);
    schedule();
    drain("single2");

    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        pend[i].push_back(8'h41 + 8'(i));
    schedule();
    drain("abc");

    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(3, 0);
        for (int b = 0; b < n; b++)
          pend[i].push_back(8'($urandom));
      end
      schedule();
      drain("rand");
    end
    check("err_before_timeout", 32'(err), 32'd0);

    // uart_m never goes busy: byte is abandoned.
    @(negedge clk);
    dead = 1'b1;
    pend[0].push_back(8'he7);
    got.idx = '0;
    got.dat = 8'he7;
    lq.push_back(got);
    n = 0;
    while (!load && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_load_seen", 32'(load), 32'd1);
    void'(pend[0].pop_front());
    mptr = 1;
    k = 0;
    while (!err && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("to_cycles", 32'(k), 32'(TO + 2));
    check("to_err", 32'(err), 32'd1);
    check("to_idle", 32'(active), 32'd0);
    dead = 1'b0;
    drain("timeout");

    @(negedge clk);
    pend[0].push_back(8'h11);
    pend[1].push_back(8'h22);
    schedule();
    drain("after_to");
    check("err_sticky", 32'(err), 32'd1);

    // Foreign busy: no load until txbusy falls.
    @(negedge clk);
    fbusy = 1'b1;
    pend[0].push_back(8'h3c);
    schedule();
    repeat (8) begin
      @(negedge clk);
      check("fb_noload", 32'(load), 32'd0);
    end
    fbusy = 1'b0;
    @(negedge clk);
    check("fb_load_next", 32'(load), 32'd1);
    drain("foreign");

    // Reset while waiting for txbusy to fall.
    lo = 8;
    @(negedge clk);
    pend[1].push_back(8'h99);
    schedule();
    n = 0;
    while (ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rm_ack_seen", 32'(ack), 32'b010);
    @(negedge clk);
    check("rm_waitlo", 32'(active & txbusy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rm_load", 32'(load), 32'd0);
    check("rm_ack", 32'(ack), 32'd0);
    check("rm_active", 32'(active), 32'd0);
    check("rm_err", 32'(err), 32'd0);
    check("rm_gnt", 32'(gnt), 32'd0);
    check("rm_d", 32'(d), 32'd0);
    lq.delete();
    aq.delete();
    mptr = 0;
    @(negedge clk);
    rst = 1'b0;
    pend[0].push_back(8'h77);
    schedule();
    n = 0;
    while (txbusy && n < 20) begin
      check("rm_hold", 32'(load), 32'd0);
      @(negedge clk);
      n++;
    end
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
